// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline latch with a req/ack data-memory port and write-back hand-off.
// Define EX_MEM_TIMEOUT_EN to add an ack watchdog of TIMEOUT_CYCLES cycles.
module ex_mem_stage #(
    parameter int DATA_W         = 32,
    parameter int REG_W          = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              ex_branch,
    input  logic              ex_is_branch,
    input  logic [DATA_W-1:0] ex_target,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              flush,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic              align_err,
    output logic              dmem_err,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu_out;
        logic              branch;
        logic              is_branch;
        logic [DATA_W-1:0] target;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  rd;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
    } ex_mem_t;

    ex_mem_t     q;
    logic [0:0]  state;
    logic        done_q;
    logic        timeout;
    logic        cap_mem;
    logic        mem_q;
    logic        mis_q;
    logic        acc_ack;
    logic        acc_to;
    logic        idle_ld;

    assign stall_out = (state == ACCESS) & ~dmem_ack;
    assign cap_mem   = ex_valid & ~flush
                     & (ex_mem_read | ex_mem_write)
                     & (ex_alu_out[1:0] == 2'b00);

    assign mem_q = q.mem_read | q.mem_write;
    assign mis_q = q.alu_out[1:0] != 2'b00;

    assign dmem_req   = state == ACCESS;
    assign dmem_we    = (state == ACCESS) & q.mem_write;
    assign dmem_addr  = q.alu_out;
    assign dmem_wdata = q.wdata;

    assign pc_src    = q.valid & q.is_branch & q.branch;
    assign pc_target = q.target;

    assign acc_ack = (state == ACCESS) & dmem_ack;
    assign acc_to  = (state == ACCESS) & timeout;
    assign idle_ld = (state == IDLE) & ~done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!stall_out) begin
            q.valid      <= ex_valid & ~flush;
            q.alu_out    <= ex_alu_out;
            q.branch     <= ex_branch;
            q.is_branch  <= ex_is_branch;
            q.target     <= ex_target;
            q.wdata      <= ex_wdata;
            q.rd         <= ex_rd;
            q.mem_read   <= ex_mem_read;
            q.mem_write  <= ex_mem_write;
            q.reg_write  <= ex_reg_write;
            q.mem_to_reg <= ex_mem_to_reg;
        end
    end

    // The ack edge doubles as the next capture edge, so back-to-back ops chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (!stall_out) begin
            state <= cap_mem ? ACCESS : IDLE;
        end else if (timeout) begin
            state <= IDLE;
        end
    end

    // A timed-out op stays in the latch one more cycle; keep it from retiring twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= acc_to;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            align_err    <= 1'b0;
            dmem_err     <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            align_err    <= 1'b0;
            dmem_err     <= 1'b0;
            unique case (1'b1)
                acc_ack: begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= q.reg_write & ~q.mem_write;
                    wb_rd        <= q.rd;
                    wb_data      <= q.mem_to_reg ? dmem_rdata : q.alu_out;
                end
                acc_to: begin
                    wb_valid <= 1'b1;
                    wb_rd    <= q.rd;
                    dmem_err <= 1'b1;
                end
                idle_ld: begin
                    wb_valid     <= q.valid;
                    wb_reg_write <= q.valid & q.reg_write & ~q.mem_write
                                  & ~(mem_q & mis_q);
                    wb_rd        <= q.rd;
                    wb_data      <= q.mem_to_reg ? dmem_rdata : q.alu_out;
                    align_err    <= q.valid & mem_q & mis_q;
                end
                default: ;
            endcase
        end
    end

`ifdef EX_MEM_TIMEOUT_EN
    localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;

    logic [CNT_W-1:0] cnt_q;

    assign timeout = stall_out
                   & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!stall_out || timeout) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and randomized checks of ex_mem_stage against a per-instruction
// outcome model (stall count, request, write-back and error pulses).
module tb_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_alu_out;
    logic        ex_branch;
    logic        ex_is_branch;
    logic [31:0] ex_target;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        flush;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        align_err;
    logic        dmem_err;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    ex_mem_stage #(
        .DATA_W(32),
        .REG_W(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ex_valid(ex_valid),
        .ex_alu_out(ex_alu_out),
        .ex_branch(ex_branch),
        .ex_is_branch(ex_is_branch),
        .ex_target(ex_target),
        .ex_wdata(ex_wdata),
        .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg),
        .flush(flush),
        .stall_out(stall_out),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .pc_src(pc_src),
        .pc_target(pc_target),
        .align_err(align_err),
        .dmem_err(dmem_err),
        .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd),
        .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        ex_valid      = 1'b0;
        ex_alu_out    = '0;
        ex_branch     = 1'b0;
        ex_is_branch  = 1'b0;
        ex_target     = '0;
        ex_wdata      = '0;
        ex_rd         = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic drive(input logic v, fl, mr, mw, rw, m2r, isbr, br,
                         input logic [31:0] alu, tgt, wd,
                         input logic [4:0] rd);
        ex_valid      = v;
        flush         = fl;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_reg_write  = rw;
        ex_mem_to_reg = m2r;
        ex_is_branch  = isbr;
        ex_branch     = br;
        ex_alu_out    = alu;
        ex_target     = tgt;
        ex_wdata      = wd;
        ex_rd         = rd;
    endtask

    // One instruction followed by bubbles; dly = ack-low cycles before ack.
    task automatic do_op(input logic v, fl, mr, mw, rw, m2r, isbr, br,
                         input logic [31:0] alu, tgt, wd, rdata,
                         input logic [4:0] rd, input int dly);
        logic live, mem, mis, acc, exp_rw;
        live   = v & ~fl;
        mem    = mr | mw;
        mis    = alu[1:0] != 2'b00;
        acc    = live & mem & ~mis;
        exp_rw = live & rw & ~mw & ~(mem & mis);
        drive(v, fl, mr, mw, rw, m2r, isbr, br, alu, tgt, wd, rd);
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        cyc();
        bubble();
        dmem_ack = 1'b0;
        if (acc) begin
            for (int i = 0; i < dly; i++) begin
                #1;
                chk("stall_wait", 32'(stall_out), 32'd1);
                chk("req_wait", 32'(dmem_req), 32'd1);
                chk("we_hold", 32'(dmem_we), 32'(mw));
                chk("addr_hold", dmem_addr, alu);
                if (mw) chk("wdata_hold", dmem_wdata, wd);
                cyc();
            end
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
            #1;
            chk("stall_ack", 32'(stall_out), 32'd0);
            chk("req_ack", 32'(dmem_req), 32'd1);
            cyc();
            dmem_ack = 1'b0;
        end else begin
            #1;
            chk("no_req", 32'(dmem_req), 32'd0);
            chk("no_stall", 32'(stall_out), 32'd0);
            chk("pc_src", 32'(pc_src), 32'(live & isbr & br));
            if (live & isbr & br) chk("pc_target", pc_target, tgt);
            cyc();
        end
        chk("wb_valid", 32'(wb_valid), 32'(live));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(exp_rw));
        if (live) chk("wb_rd", 32'(wb_rd), 32'(rd));
        if (exp_rw) chk("wb_data", wb_data, (acc && m2r) ? rdata : alu);
        chk("align_err", 32'(align_err), 32'(live & mem & mis));
        chk("dmem_err", 32'(dmem_err), 32'd0);
        chk("pc_src_1cyc", 32'(pc_src), 32'd0);
        chk("req_idle", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          kind;
        logic        v, fl, rw, br, mw;
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        bubble();
        #2;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_pc_src", 32'(pc_src), 32'd0);
        chk("rst_align", 32'(align_err), 32'd0);
        chk("rst_dmem_err", 32'(dmem_err), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_pc_target", pc_target, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // add, load with 3 stalls, store, taken/untaken beq, misaligned, flush
        do_op(1, 0, 0, 0, 1, 0, 0, 0, 32'h10, 0, 0, 0, 5'd5, 0);
        do_op(1, 0, 1, 0, 1, 1, 0, 0, 32'h100, 0, 0, 32'hDEADBEEF, 5'd7, 3);
        do_op(1, 0, 0, 1, 0, 0, 0, 0, 32'h204, 0, 32'h12345678, 0, 5'd0, 0);
        do_op(1, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h40, 0, 0, 5'd0, 0);
        do_op(1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h40, 0, 0, 5'd0, 0);
        do_op(1, 0, 1, 0, 1, 1, 0, 0, 32'h102, 0, 0, 0, 5'd3, 0);
        do_op(1, 1, 0, 0, 1, 0, 0, 0, 32'h55, 0, 0, 0, 5'd9, 0);

        // back-to-back: store captured on the load's ack edge
        drive(1, 0, 1, 0, 1, 1, 0, 0, 32'h300, 0, 0, 5'd11);
        cyc();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 32'h204, 0, 32'hCAFEF00D, 5'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hA5A5_0001;
        #1;
        chk("b2b_stall", 32'(stall_out), 32'd0);
        cyc();
        bubble();
        chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
        chk("b2b_wb_data", wb_data, 32'hA5A5_0001);
        chk("b2b_wb_rd", 32'(wb_rd), 32'd11);
        chk("b2b_req", 32'(dmem_req), 32'd1);
        chk("b2b_we", 32'(dmem_we), 32'd1);
        chk("b2b_addr", dmem_addr, 32'h204);
        chk("b2b_wdata", dmem_wdata, 32'hCAFEF00D);
        cyc();
        dmem_ack = 1'b0;
        chk("b2b_st_wb", 32'(wb_valid), 32'd1);
        chk("b2b_st_rw", 32'(wb_reg_write), 32'd0);
        chk("b2b_req_end", 32'(dmem_req), 32'd0);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 4));
            v    = ($urandom_range(0, 7) != 0);
            fl   = ($urandom_range(0, 5) == 0);
            rw   = 1'($urandom_range(0, 1));
            br   = 1'($urandom_range(0, 1));
            mw   = 1'($urandom_range(0, 1));
            r    = $urandom;
            a    = {r[31:2], 2'b00};
            case (kind)
                0: do_op(v, fl, 0, 0, rw, 0, 0, 0, r, $urandom, 0, 0,
                         5'($urandom), 0);
                1: do_op(v, fl, 1, 0, 1, 1, 0, 0, a, 0, 0, $urandom,
                         5'($urandom), int'($urandom_range(0, 3)));
                2: do_op(v, fl, 0, 1, rw, 0, 0, 0, a, 0, $urandom, 0,
                         5'($urandom), int'($urandom_range(0, 3)));
                3: do_op(v, fl, 0, 0, 0, 0, 1, br, r, $urandom, 0, 0,
                         5'd0, 0);
                default: do_op(v, fl, ~mw, mw, rw, ~mw, 0, 0,
                               {r[31:2], 2'($urandom_range(1, 3))},
                               0, $urandom, 0, 5'($urandom), 0);
            endcase
        end

`ifdef EX_MEM_TIMEOUT_EN
        drive(1, 0, 1, 0, 1, 1, 0, 0, 32'h400, 0, 0, 5'd2);
        cyc();
        bubble();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_stall", 32'(stall_out), 32'd1);
            cyc();
        end
        chk("to_dmem_err", 32'(dmem_err), 32'd1);
        chk("to_wb_valid", 32'(wb_valid), 32'd1);
        chk("to_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("to_release", 32'(stall_out), 32'd0);
        chk("to_req", 32'(dmem_req), 32'd0);
        cyc();
        chk("to_once", 32'(wb_valid), 32'd0);
        chk("to_err_pulse", 32'(dmem_err), 32'd0);
`endif

        // reset while an access is outstanding
        drive(1, 0, 1, 0, 1, 1, 0, 0, 32'h500, 0, 0, 5'd4);
        cyc();
        bubble();
        dmem_ack = 1'b0;
        #1;
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        chk("pre_rst_stall", 32'(stall_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_stall", 32'(stall_out), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        do_op(1, 0, 0, 0, 1, 0, 0, 0, 32'h77, 0, 0, 0, 5'd8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
